mux_rr_arbiter: RTL and testbench

- Shares one 4-to-1 byte datapath (inputs D0..D3, data_t from soc_pkg) among four requesters.
- Uses a round-robin arbiter to generate the mux select.
- The selected word is registered into a valid/ready output stage.
- Sits between four producer blocks and one consumer. It is the sequencing and sharing controller for the 4-to-1 select path.

---
 rtl/mux_rr_arbiter.sv | 108 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin shared 4-to-1 byte datapath with a registered valid/ready output stage.
// Optional owner lock when MUX_ARB_LOCK_EN is defined; otherwise pure round-robin.
package soc_pkg;
  localparam int DATA_WIDTH = 8;
  typedef logic [DATA_WIDTH-1:0] data_t;
endpackage

module mux_rr_arbiter
  import soc_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  data_t                D0,
  input  data_t                D1,
  input  data_t                D2,
  input  data_t                D3,
  input  logic                 lock,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output data_t                out_data,
  output logic [1:0]           out_src,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_r;
  logic [1:0]  ptr_r;
  logic [1:0]  rr_win_s;
  logic [1:0]  cand_s;
  logic [1:0]  winner_s;
  logic        lock_hit_s;
  logic        load_s;
  logic        hshake_s;
  data_t       sel_data_s;

  // Round-robin scan from ptr; lower offsets overwrite higher ones, so the nearest requester wins.
  always_comb begin
    rr_win_s = ptr_r;
    cand_s   = ptr_r;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = ptr_r + 2'(k);
      if (req[cand_s]) begin
        rr_win_s = cand_s;
      end else begin
        rr_win_s = rr_win_s;
      end
    end
  end

`ifdef MUX_ARB_LOCK_EN
  assign lock_hit_s = lock & (state_r == BUSY) & req[out_src];
`else
  assign lock_hit_s = lock & 1'b0;
`endif

  assign winner_s = lock_hit_s ? out_src : rr_win_s;
  assign hshake_s = out_valid & out_ready;
  assign load_s   = rst_n & (|req) &
                    ((state_r == IDLE) | ((state_r == BUSY) & hshake_s));
  assign gnt      = load_s ? (NUM_REQ'(1) << winner_s) : NUM_REQ'(0);

  // Data select for the winning requester.
  always_comb begin
    case (winner_s)
      2'd0:    sel_data_s = D0;
      2'd1:    sel_data_s = D1;
      2'd2:    sel_data_s = D2;
      2'd3:    sel_data_s = D3;
      default: sel_data_s = D0;
    endcase
  end

  // Output stage, pointer, state and transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      xfer_cnt  <= '0;
    end else begin
      if (hshake_s) begin
        xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
      end
      if (load_s) begin
        out_data  <= sel_data_s;
        out_src   <= winner_s;
        out_valid <= 1'b1;
        state_r   <= BUSY;
        // A locked reload keeps the owner, so the rotation stays where it was.
        if (!lock_hit_s) begin
          ptr_r <= winner_s + 2'd1;
        end
      end else if (hshake_s) begin
        out_valid <= 1'b0;
        state_r   <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with hand-computed expectations.
// Lock expectations follow MUX_ARB_LOCK_EN as compiled.
module tb_mux_rr_arbiter;
  import soc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  data_t       d0, d1, d2, d3;
  logic        lock;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  data_t       out_data;
  logic [1:0]  out_src;
  logic [15:0] xfer_cnt;

  int n_total = 0;
  int n_bad   = 0;

  mux_rr_arbiter #(.NUM_REQ(4), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .D0        (d0),
    .D1        (d1),
    .D2        (d2),
    .D3        (d3),
    .lock      (lock),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] rr_data [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA};
  logic [1:0] rr_src  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`ifdef MUX_ARB_LOCK_EN
  logic [3:0] lk_gnt  [2] = '{4'b0001, 4'b0001};
  logic [7:0] lk_data [2] = '{8'hAA, 8'hAA};
  logic [1:0] lk_src  [2] = '{2'd0, 2'd0};
`else
  logic [3:0] lk_gnt  [2] = '{4'b0010, 4'b0100};
  logic [7:0] lk_data [2] = '{8'hBB, 8'hCC};
  logic [1:0] lk_src  [2] = '{2'd1, 2'd2};
`endif

  initial begin
    rst_n = 1'b0; req = 4'b1111; lock = 1'b0; out_ready = 1'b0;
    d0 = 8'hAA; d1 = 8'hBB; d2 = 8'hCC; d3 = 8'hDD;

    // Reset state, with requests pending that must not be granted.
    step();
    chk_val("rst_valid", 32'(out_valid), 32'd0);
    chk_val("rst_data",  32'(out_data),  32'h00);
    chk_val("rst_src",   32'(out_src),   32'd0);
    chk_val("rst_cnt",   32'(xfer_cnt),  32'd0);
    chk_val("rst_gnt",   32'(gnt),       32'h0);

    // Single request, one cycle latency, then back to idle.
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0001; out_ready = 1'b1;
    #1 chk_val("t1_gnt", 32'(gnt), 32'h1);
    step();
    chk_val("t1_valid", 32'(out_valid), 32'd1);
    chk_val("t1_data",  32'(out_data),  32'hAA);
    chk_val("t1_src",   32'(out_src),   32'd0);
    req = 4'b0000;
    #1 chk_val("t1_gnt_off", 32'(gnt), 32'h0);
    step();
    chk_val("t1_idle", 32'(out_valid), 32'd0);
    chk_val("t1_cnt",  32'(xfer_cnt),  32'd1);

    // All four requesting: strict rotation with no bubbles.
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk_val($sformatf("t2_gnt%0d", i), 32'(gnt), 32'(rr_gnt[i]));
      step();
      chk_val($sformatf("t2_valid%0d", i), 32'(out_valid), 32'd1);
      chk_val($sformatf("t2_data%0d", i),  32'(out_data),  32'(rr_data[i]));
      chk_val($sformatf("t2_src%0d", i),   32'(out_src),   32'(rr_src[i]));
    end
    chk_val("t2_cnt", 32'(xfer_cnt), 32'd4);

    // Backpressure on BB.
    step();
    chk_val("t3_data_ld", 32'(out_data), 32'hBB);
    chk_val("t3_cnt_ld",  32'(xfer_cnt), 32'd5);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk_val($sformatf("t3_gnt%0d", i), 32'(gnt), 32'h0);
      step();
      chk_val($sformatf("t3_hold%0d", i), 32'(out_data),  32'hBB);
      chk_val($sformatf("t3_vld%0d", i),  32'(out_valid), 32'd1);
      chk_val($sformatf("t3_cnt%0d", i),  32'(xfer_cnt),  32'd5);
    end
    req = 4'b0000; out_ready = 1'b1;
    step();
    chk_val("t3_release_vld", 32'(out_valid), 32'd0);
    chk_val("t3_release_cnt", 32'(xfer_cnt),  32'd6);

    // Pointer wrap: owner 2 leaves ptr at 3, then 0 and 1 are served.
    req = 4'b0100;
    #1 chk_val("t4_gnt2", 32'(gnt), 32'h4);
    step();
    chk_val("t4_src2", 32'(out_src), 32'd2);
    req = 4'b0011;
    #1 chk_val("t4_gnt0", 32'(gnt), 32'h1);
    step();
    chk_val("t4_data0", 32'(out_data), 32'hAA);
    chk_val("t4_src0",  32'(out_src),  32'd0);
    #1 chk_val("t4_gnt1", 32'(gnt), 32'h2);
    step();
    chk_val("t4_data1", 32'(out_data), 32'hBB);
    chk_val("t4_src1",  32'(out_src),  32'd1);
    req = 4'b0000;
    step();
    chk_val("t4_idle", 32'(out_valid), 32'd0);
    chk_val("t4_cnt",  32'(xfer_cnt),  32'd9);

    // Asynchronous reset while a word is pending.
    req = 4'b1111; out_ready = 1'b0;
    step();
    chk_val("t5_busy", 32'(out_valid), 32'd1);
    chk_val("t5_data", 32'(out_data),  32'hCC);
    #2 rst_n = 1'b0;
    #1;
    chk_val("t5_async_vld", 32'(out_valid), 32'd0);
    chk_val("t5_async_dat", 32'(out_data),  32'h00);
    chk_val("t5_async_cnt", 32'(xfer_cnt),  32'd0);
    chk_val("t5_async_gnt", 32'(gnt),       32'h0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk_val("t5_gnt", 32'(gnt), 32'h1);
    step();
    chk_val("t5_first", 32'(out_data), 32'hAA);

    // Lock after the first grant.
    lock = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 chk_val($sformatf("t6_gnt%0d", i), 32'(gnt), 32'(lk_gnt[i]));
      step();
      chk_val($sformatf("t6_src%0d", i),  32'(out_src),  32'(lk_src[i]));
      chk_val($sformatf("t6_data%0d", i), 32'(out_data), 32'(lk_data[i]));
    end
    lock = 1'b0; req = 4'b0000;
    step();
    chk_val("t6_idle", 32'(out_valid), 32'd0);
    chk_val("t6_cnt",  32'(xfer_cnt),  32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
